arb_mux_reg: RTL and testbench

Parametrised, registered N-channel word multiplexer with valid/ready handshakes on every input and on the output. It runs in one of two modes: externally selected, which generalises the fixed 32-bit 4:1 datapath mux, or round-robin arbitration. It sits between multiple producers and a single consumer, for example register-file write-back sources, memory request ports or stage-boundary buffers. The output stage is a one-entry register, so downstream timing is cut.

---
 rtl/arb_mux_reg.sv | 93 +++++++++
 tb/tb_arb_mux_reg.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/arb_mux_reg.sv
// arb_mux_reg: registered N-channel word multiplexer with valid/ready handshakes.
// MODE 0 forwards the channel chosen by sel; MODE 1 arbitrates round-robin.
// The output is a single-entry register, so there is no combinational path
// from any input channel to out_*.
module arb_mux_reg #(
  parameter int WIDTH = 32,
  parameter int NCH   = 4,
  parameter int MODE  = 0,
  parameter int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);

  localparam logic [SELW-1:0] LAST = SELW'(NCH - 1);

  logic [SELW-1:0]  ptr;
  logic [NCH-1:0]   g;
  logic [SELW-1:0]  gidx;
  logic             found;
  logic [WIDTH-1:0] word;
  logic             load_en;
  int unsigned      idx;

  assign load_en = !out_valid || out_ready;

  // Grant: one-hot or zero; MODE 1 scans upward from ptr with wrap-around.
  always_comb begin
    g     = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = 0;
    if (MODE == 0) begin
      for (int unsigned i = 0; i < NCH; i++) begin
        if ((32'(sel) == i) && in_valid[i]) begin
          g[i] = 1'b1;
          gidx = SELW'(i);
        end
      end
    end else begin
      for (int unsigned k = 0; k < NCH; k++) begin
        idx = 32'(ptr) + k;
        if (idx >= NCH) idx = idx - NCH;
        if (!found && in_valid[idx]) begin
          found  = 1'b1;
          g[idx] = 1'b1;
          gidx   = SELW'(idx);
        end
      end
    end
  end

  // Word selection as an AND-OR mux over the one-hot grant.
  always_comb begin
    word = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      if (g[i]) word = word | in_data[i*WIDTH +: WIDTH];
    end
  end

  // Handshake back to producers; suppressed while reset is held low.
  always_comb begin
    in_ready = g & {NCH{load_en & reset}};
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk) begin
    if (!reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      ptr       <= '0;
    end else if (load_en) begin
      if (|g) begin
        out_data  <= word;
        out_ch    <= gidx;
        out_valid <= 1'b1;
        if (MODE == 1) ptr <= (gidx == LAST) ? '0 : gidx + 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_arb_mux_reg.sv
// Directed bench for arb_mux_reg: four instances cover MODE 0/1 at NCH=4 and NCH=3.
module tb_arb_mux_reg;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // dut0: MODE 0, NCH 4
  logic [127:0] d0;  logic [3:0] v0, r0;  logic [1:0] s0, oc0;
  logic [31:0] od0;  logic ov0, ordy0;
  // dut1: MODE 1, NCH 4
  logic [127:0] d1;  logic [3:0] v1, r1;  logic [1:0] s1, oc1;
  logic [31:0] od1;  logic ov1, ordy1;
  // dut2: MODE 0, NCH 3
  logic [95:0] d2;   logic [2:0] v2, r2;  logic [1:0] s2, oc2;
  logic [31:0] od2;  logic ov2, ordy2;
  // dut3: MODE 1, NCH 3
  logic [95:0] d3;   logic [2:0] v3, r3;  logic [1:0] s3, oc3;
  logic [31:0] od3;  logic ov3, ordy3;

  arb_mux_reg #(.WIDTH(32), .NCH(4), .MODE(0)) dut0 (
    .clk(clk), .reset(reset), .in_data(d0), .in_valid(v0), .in_ready(r0), .sel(s0),
    .out_data(od0), .out_valid(ov0), .out_ready(ordy0), .out_ch(oc0));
  arb_mux_reg #(.WIDTH(32), .NCH(4), .MODE(1)) dut1 (
    .clk(clk), .reset(reset), .in_data(d1), .in_valid(v1), .in_ready(r1), .sel(s1),
    .out_data(od1), .out_valid(ov1), .out_ready(ordy1), .out_ch(oc1));
  arb_mux_reg #(.WIDTH(32), .NCH(3), .MODE(0)) dut2 (
    .clk(clk), .reset(reset), .in_data(d2), .in_valid(v2), .in_ready(r2), .sel(s2),
    .out_data(od2), .out_valid(ov2), .out_ready(ordy2), .out_ch(oc2));
  arb_mux_reg #(.WIDTH(32), .NCH(3), .MODE(1)) dut3 (
    .clk(clk), .reset(reset), .in_data(d3), .in_valid(v3), .in_ready(r3), .sel(s3),
    .out_data(od3), .out_valid(ov3), .out_ready(ordy3), .out_ch(oc3));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    d0 = '0; v0 = '0; s0 = '0; ordy0 = 1'b1;
    d1 = '0; v1 = '0; s1 = '0; ordy1 = 1'b1;
    d2 = '0; v2 = '0; s2 = '0; ordy2 = 1'b1;
    d3 = '0; v3 = '0; s3 = '0; ordy3 = 1'b1;
    tick();
    v0 = 4'hf; v1 = 4'hf; v2 = 3'h7; v3 = 3'h7;
    #1;
    checks++; if (r0 !== 4'h0) begin errors++; $display("FAIL rst_ready0 got %h exp 0", r0); end
    checks++; if (r1 !== 4'h0) begin errors++; $display("FAIL rst_ready1 got %h exp 0", r1); end
    tick();
    checks++; if (ov0 !== 1'b0 || od0 !== 32'h0 || oc0 !== 2'd0) begin
      errors++; $display("FAIL rst_out0 got v=%b d=%h ch=%0d exp 0/0/0", ov0, od0, oc0); end
    checks++; if (ov1 !== 1'b0 || od1 !== 32'h0 || oc1 !== 2'd0) begin
      errors++; $display("FAIL rst_out1 got v=%b d=%h ch=%0d exp 0/0/0", ov1, od1, oc1); end
    checks++; if (ov2 !== 1'b0 || ov3 !== 1'b0) begin
      errors++; $display("FAIL rst_out23 got %b %b exp 0 0", ov2, ov3); end
    v0 = '0; v1 = '0; v2 = '0; v3 = '0;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_sel_sweep();
    for (int i = 0; i < 4; i++) d0[i*32 +: 32] = 32'hA0A0A0A0 + 32'(i);
    v0 = 4'hf; ordy0 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      s0 = 2'(i);
      #1;
      checks++; if (r0 !== 4'(1 << i)) begin
        errors++; $display("FAIL sweep_ready%0d got %b exp %b", i, r0, 4'(1 << i)); end
      tick();
      checks++; if (od0 !== 32'hA0A0A0A0 + 32'(i) || oc0 !== 2'(i) || ov0 !== 1'b1) begin
        errors++; $display("FAIL sweep_out%0d got d=%h ch=%0d v=%b exp d=%h ch=%0d v=1",
                           i, od0, oc0, ov0, 32'hA0A0A0A0 + 32'(i), i); end
    end
    v0 = '0;
    tick();
    checks++; if (ov0 !== 1'b0 || od0 !== 32'hA0A0A0A3 || oc0 !== 2'd3) begin
      errors++; $display("FAIL sweep_drain got v=%b d=%h ch=%0d exp v=0 d=a0a0a0a3 ch=3", ov0, od0, oc0); end
  endtask

  task automatic test_stall();
    d0 = {32'h0, 32'h12345678, 32'h0, 32'h0};
    v0 = 4'hf; s0 = 2'd2; ordy0 = 1'b1;
    tick();
    ordy0 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      s0 = 2'(k);
      d0 = {4{32'h5A5A0000 + 32'(k)}};
      #1;
      checks++; if (r0 !== 4'h0) begin
        errors++; $display("FAIL stall_ready%0d got %b exp 0000", k, r0); end
      tick();
      checks++; if (od0 !== 32'h12345678 || oc0 !== 2'd2 || ov0 !== 1'b1) begin
        errors++; $display("FAIL stall_hold%0d got d=%h ch=%0d v=%b exp d=12345678 ch=2 v=1",
                           k, od0, oc0, ov0); end
    end
    ordy0 = 1'b1; s0 = 2'd1;
    d0 = {32'h0, 32'h0, 32'hCAFE0001, 32'h0};
    #1;
    checks++; if (r0 !== 4'b0010) begin
      errors++; $display("FAIL stall_release_ready got %b exp 0010", r0); end
    tick();
    checks++; if (od0 !== 32'hCAFE0001 || oc0 !== 2'd1 || ov0 !== 1'b1) begin
      errors++; $display("FAIL stall_release_out got d=%h ch=%0d v=%b exp cafe0001 1 1", od0, oc0, ov0); end
    v0 = '0;
    tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) d1[i*32 +: 32] = 32'h1000 + 32'(i);
    v1 = 4'hf; ordy1 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++; if (r1 !== 4'(1 << (k % 4))) begin
        errors++; $display("FAIL rr_ready%0d got %b exp %b", k, r1, 4'(1 << (k % 4))); end
      tick();
      checks++; if (oc1 !== 2'(k % 4) || ov1 !== 1'b1 || od1 !== 32'h1000 + 32'(k % 4)) begin
        errors++; $display("FAIL rr_out%0d got ch=%0d v=%b d=%h exp ch=%0d v=1 d=%h",
                           k, oc1, ov1, od1, k % 4, 32'h1000 + 32'(k % 4)); end
    end
    v1 = '0;
    tick();
    checks++; if (ov1 !== 1'b0) begin errors++; $display("FAIL rr_idle got v=%b exp 0", ov1); end
  endtask

  task automatic test_rr_sparse();
    logic [1:0] exp_ch [6] = '{2'd1, 2'd3, 2'd1, 2'd3, 2'd1, 2'd1};
    for (int i = 0; i < 4; i++) d1[i*32 +: 32] = 32'h2000 + 32'(i);
    ordy1 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      v1 = (k < 4) ? 4'b1010 : 4'b0010;
      tick();
      checks++; if (oc1 !== exp_ch[k] || ov1 !== 1'b1 || od1 !== 32'h2000 + 32'(exp_ch[k])) begin
        errors++; $display("FAIL sparse%0d got ch=%0d v=%b d=%h exp ch=%0d v=1", k, oc1, ov1, od1, exp_ch[k]); end
    end
    v1 = '0;
    repeat (3) tick();
    v1 = 4'b1010;
    #1;
    checks++; if (r1 !== 4'b1000) begin
      errors++; $display("FAIL sparse_ptr_ready got %b exp 1000", r1); end
    tick();
    checks++; if (oc1 !== 2'd3 || od1 !== 32'h2003) begin
      errors++; $display("FAIL sparse_ptr_out got ch=%0d d=%h exp ch=3 d=2003", oc1, od1); end
    v1 = '0;
    tick();
  endtask

  task automatic test_reset_mid();
    d1 = {32'h0, 32'hDEADBEEF, 32'h0, 32'h0};
    v1 = 4'b0100; ordy1 = 1'b1;
    tick();
    v1 = '0; ordy1 = 1'b0;
    tick();
    checks++; if (ov1 !== 1'b1 || od1 !== 32'hDEADBEEF || oc1 !== 2'd2) begin
      errors++; $display("FAIL mid_hold got v=%b d=%h ch=%0d exp 1 deadbeef 2", ov1, od1, oc1); end
    reset = 1'b0; v1 = 4'hf; ordy1 = 1'b1;
    #1;
    checks++; if (r1 !== 4'h0) begin
      errors++; $display("FAIL mid_rst_ready got %b exp 0000", r1); end
    tick();
    checks++; if (ov1 !== 1'b0 || od1 !== 32'h0 || oc1 !== 2'd0) begin
      errors++; $display("FAIL mid_rst_out got v=%b d=%h ch=%0d exp 0 0 0", ov1, od1, oc1); end
    reset = 1'b1; v1 = 4'b1110;
    d1 = {32'h3003, 32'h3002, 32'h3001, 32'h3000};
    #1;
    checks++; if (r1 !== 4'b0010) begin
      errors++; $display("FAIL mid_first_ready got %b exp 0010", r1); end
    tick();
    checks++; if (oc1 !== 2'd1 || od1 !== 32'h3001 || ov1 !== 1'b1) begin
      errors++; $display("FAIL mid_first_out got ch=%0d d=%h v=%b exp 1 3001 1", oc1, od1, ov1); end
    v1 = '0;
    tick();
  endtask

  task automatic test_nch3();
    d2 = {32'h302, 32'h301, 32'h300};
    v2 = 3'h7; ordy2 = 1'b1; s2 = 2'd0;
    tick();
    checks++; if (ov2 !== 1'b1 || od2 !== 32'h300 || oc2 !== 2'd0) begin
      errors++; $display("FAIL n3_load got v=%b d=%h ch=%0d exp 1 300 0", ov2, od2, oc2); end
    s2 = 2'd3;
    #1;
    checks++; if (r2 !== 3'b000) begin
      errors++; $display("FAIL n3_sel3_ready got %b exp 000", r2); end
    tick();
    checks++; if (ov2 !== 1'b0 || od2 !== 32'h300) begin
      errors++; $display("FAIL n3_sel3_drain got v=%b d=%h exp 0 300", ov2, od2); end
    v2 = '0;
    d3 = {32'h402, 32'h401, 32'h400};
    v3 = 3'h7; ordy3 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++; if (r3 !== 3'(1 << (k % 3))) begin
        errors++; $display("FAIL n3_rr_ready%0d got %b exp %b", k, r3, 3'(1 << (k % 3))); end
      tick();
      checks++; if (oc3 !== 2'(k % 3) || ov3 !== 1'b1 || od3 !== 32'h400 + 32'(k % 3)) begin
        errors++; $display("FAIL n3_rr_out%0d got ch=%0d v=%b d=%h exp ch=%0d", k, oc3, ov3, od3, k % 3); end
    end
    v3 = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_sel_sweep();
    test_stall();
    test_back_to_back();
    test_rr_sparse();
    test_reset_mid();
    test_nch3();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout reached without completion");
    $fatal(1);
  end

endmodule
